// File: rtl/grf_multiport_sb_pkg.sv
// Shared CPU register-file constants: default widths, port-count limits, zero register.
package grf_multiport_sb_pkg;

  localparam int unsigned GRF_DATA_W   = 32;
  localparam int unsigned GRF_ADDR_W   = 5;
  localparam int unsigned GRF_MAX_NRD  = 4;
  localparam int unsigned GRF_MAX_NWR  = 2;
  localparam int unsigned GRF_REG_ZERO = 0;

endpackage

// File: rtl/grf_multiport_sb_scoreboard.sv
// Pending-bit scoreboard: one bit per register plus a registered popcount.
module grf_scoreboard
  import grf_multiport_sb_pkg::*;
#(
  parameter int unsigned ADDR_W = GRF_ADDR_W,
  parameter int unsigned NWR    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic [NWR-1:0]        wr_act,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  output logic [(1<<ADDR_W)-1:0] pend,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] pend_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Writes retire producers; a same-cycle issue is applied last so the new producer wins.
  always_comb begin
    pend_nxt = pend;
    cnt_nxt  = '0;
    for (int unsigned p = 0; p < NWR; p++) begin
      if (wr_act[p]) pend_nxt[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (iss_en && (iss_addr != ADDR_W'(GRF_REG_ZERO))) pend_nxt[iss_addr] = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(pend_nxt[i]);
    end
  end

  // Pending bits and their count; reset drops any issue in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend     <= '0;
      busy_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/grf_multiport_sb.sv
// Multi-port general register file with write-to-read bypass and issue scoreboard.
module grf_multiport_sb
  import grf_multiport_sb_pkg::*;
#(
  parameter int unsigned DATA_W = GRF_DATA_W,
  parameter int unsigned ADDR_W = GRF_ADDR_W,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]       busy_cnt,
  output logic                  wr_conflict
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [NWR-1:0]    wr_act_c;
  logic              wr_conflict_c;
  logic [DEPTH-1:0]  pend;

  // Effective write strobes: out of reset and never to the zero register.
  always_comb begin
    wr_act_c = '0;
    for (int unsigned p = 0; p < NWR; p++) begin
      wr_act_c[p] = reset && wr_en[p] &&
                    (wr_addr[p*ADDR_W +: ADDR_W] != ADDR_W'(GRF_REG_ZERO));
    end
  end

  // Any two active write ports aiming at the same register.
  always_comb begin
    wr_conflict_c = 1'b0;
    for (int unsigned i = 0; i < NWR; i++) begin
      for (int unsigned j = i + 1; j < NWR; j++) begin
        if (wr_act_c[i] && wr_act_c[j] &&
            (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W]))
          wr_conflict_c = 1'b1;
      end
    end
  end

  // Data array; later ports are applied last so the highest index wins a collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int unsigned p = 0; p < NWR; p++) begin
        if (wr_act_c[p]) regs[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

  // Sticky collision flag.
  always_ff @(posedge clk) begin
    if (!reset) wr_conflict <= 1'b0;
    else if (wr_conflict_c) wr_conflict <= 1'b1;
  end

  // Zero-latency read ports with optional forwarding from this cycle's writes.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              hit;
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rd      = '0;
    hit     = 1'b0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra  = rd_addr[k*ADDR_W +: ADDR_W];
      rd  = (ra == ADDR_W'(GRF_REG_ZERO)) ? '0 : regs[ra];
      hit = 1'b0;
      if (BYPASS != 0) begin
        for (int unsigned p = 0; p < NWR; p++) begin
          if (wr_act_c[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ra)) begin
            rd  = wr_data[p*DATA_W +: DATA_W];
            hit = 1'b1;
          end
        end
      end
      rd_data[k*DATA_W +: DATA_W] = rd;
      rd_busy[k]                  = pend[ra] & ~hit;
    end
  end

  grf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NWR    (NWR)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_act   (wr_act_c),
    .wr_addr  (wr_addr),
    .pend     (pend),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_grf_multiport_sb.sv
// Bench for grf_multiport_sb: bypass and non-bypass instances against an array-based model.
module tb_grf_multiport_sb;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 2;
  localparam int unsigned NW    = 2;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned CW    = AW + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]   rd_busy_b, rd_busy_n;
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic [NW-1:0]   wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [CW-1:0]   cnt_b, cnt_n;
  logic            conf_b, conf_n;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_pend;
  logic             m_conf;

  always #5 clk = ~clk;

  grf_multiport_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .iss_en(iss_en), .iss_addr(iss_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy_cnt(cnt_b), .wr_conflict(conf_b)
  );

  grf_multiport_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .iss_en(iss_en), .iss_addr(iss_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy_cnt(cnt_n), .wr_conflict(conf_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] wa(input int p);
    return wr_addr[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wd(input int p);
    return wr_data[p*DW +: DW];
  endfunction

  // Is address a forwarded from a live write this cycle (last matching port wins)?
  function automatic bit m_hit(input logic [AW-1:0] a, input bit byp);
    bit h = 1'b0;
    if (byp && reset && a != '0)
      for (int p = 0; p < NW; p++) if (wr_en[p] && wa(p) == a) h = 1'b1;
    return h;
  endfunction

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a, input bit byp);
    logic [DW-1:0] d;
    d = (a == '0) ? '0 : m_mem[a];
    if (byp && reset && a != '0)
      for (int p = 0; p < NW; p++) if (wr_en[p] && wa(p) == a) d = wd(p);
    return d;
  endfunction

  task automatic idle();
    iss_en = 1'b0; iss_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  // Combinational read checks for every port of both instances.
  task automatic check_comb(input string tag);
    logic [AW-1:0] a;
    #1;
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      check($sformatf("%s/rd%0d_byp", tag, k), 64'(rd_data_b[k*DW +: DW]), 64'(m_rd(a, 1'b1)));
      check($sformatf("%s/rd%0d_nob", tag, k), 64'(rd_data_n[k*DW +: DW]), 64'(m_rd(a, 1'b0)));
      check($sformatf("%s/bz%0d_byp", tag, k), 64'(rd_busy_b[k]),
            64'(m_pend[a] && !m_hit(a, 1'b1)));
      check($sformatf("%s/bz%0d_nob", tag, k), 64'(rd_busy_n[k]), 64'(m_pend[a]));
    end
  endtask

  // Advance one edge, update the model from the architectural rules, check registered outputs.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_pend = '0;
      m_conf = 1'b0;
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (wr_en[p] && wa(p) != '0) begin
          m_mem[wa(p)]  = wd(p);
          m_pend[wa(p)] = 1'b0;
        end
      end
      if (wr_en == 2'b11 && wa(0) == wa(1) && wa(0) != '0) m_conf = 1'b1;
      if (iss_en && iss_addr != '0) m_pend[iss_addr] = 1'b1;
    end
    @(negedge clk);
    check({tag, "/cnt_byp"},  64'(cnt_b),  64'($countones(m_pend)));
    check({tag, "/cnt_nob"},  64'(cnt_n),  64'($countones(m_pend)));
    check({tag, "/conf_byp"}, 64'(conf_b), 64'(m_conf));
    check({tag, "/conf_nob"}, 64'(conf_n), 64'(m_conf));
  endtask

  initial begin
    m_pend = '0;
    m_conf = 1'b0;
    reset  = 1'b0;
    rd_addr = '0;
    idle();
    @(negedge clk);
    // Writes and issues during reset must be ignored.
    set_wr(0, 5'd6, 32'h1111_2222);
    iss_en = 1'b1; iss_addr = 5'd6;
    tick("rst0");
    tick("rst1");
    reset = 1'b1;
    idle();
    set_rd(0, 5'd6); set_rd(1, 5'd0);
    check_comb("post_rst");
    check("post_rst/r6", 64'(rd_data_b[DW-1:0]), 64'h0);
    check("post_rst/cnt", 64'(cnt_b), 64'h0);

    // Plain write then read
    idle(); set_wr(0, 5'd5, 32'hDEADBEEF);
    check_comb("w5"); tick("w5");
    idle(); set_rd(0, 5'd5);
    check_comb("r5");
    check("r5/data", 64'(rd_data_b[DW-1:0]), 64'hDEADBEEF);
    check("r5/busy", 64'(rd_busy_b[0]), 64'h0);

    // Same-cycle write and read: forwarded vs stored value
    idle(); set_wr(0, 5'd7, 32'h1234); set_rd(0, 5'd7);
    check_comb("byp7");
    check("byp7/byp", 64'(rd_data_b[DW-1:0]), 64'h1234);
    check("byp7/nob", 64'(rd_data_n[DW-1:0]), 64'h0);
    tick("byp7");

    // Issue then retire r3
    idle(); iss_en = 1'b1; iss_addr = 5'd3;
    check_comb("iss3"); tick("iss3");
    idle(); set_rd(1, 5'd3);
    check_comb("busy3");
    check("busy3/busy", 64'(rd_busy_b[1]), 64'h1);
    check("busy3/cnt", 64'(cnt_b), 64'h1);
    set_wr(0, 5'd3, 32'h55);
    check_comb("ret3");
    check("ret3/data", 64'(rd_data_b[2*DW-1:DW]), 64'h55);
    check("ret3/busy", 64'(rd_busy_b[1]), 64'h0);
    tick("ret3");
    check("ret3/cnt", 64'(cnt_b), 64'h0);

    // Dual write to r9: port 1 wins, conflict sticks
    idle(); set_wr(0, 5'd9, 32'hAAAA); set_wr(1, 5'd9, 32'hBBBB);
    check_comb("dual9"); tick("dual9");
    idle(); set_rd(0, 5'd9);
    check_comb("r9");
    check("r9/data", 64'(rd_data_b[DW-1:0]), 64'hBBBB);
    check("r9/conf", 64'(conf_b), 64'h1);
    tick("hold");
    check("hold/conf", 64'(conf_b), 64'h1);

    // Issue and write r4 together: stays pending
    idle(); iss_en = 1'b1; iss_addr = 5'd4; set_wr(0, 5'd4, 32'h77);
    check_comb("iw4"); tick("iw4");
    idle(); set_rd(1, 5'd4);
    check_comb("r4");
    check("r4/data", 64'(rd_data_b[2*DW-1:DW]), 64'h77);
    check("r4/busy", 64'(rd_busy_b[1]), 64'h1);
    check("r4/cnt", 64'(cnt_b), 64'h1);
    // Re-issue of a pending register leaves the count alone
    iss_en = 1'b1; iss_addr = 5'd4;
    tick("reiss4");
    check("reiss4/cnt", 64'(cnt_b), 64'h1);

    // Register zero is immune to issue and write
    idle(); iss_en = 1'b1; iss_addr = 5'd0; set_wr(0, 5'd0, 32'hFFFF); set_rd(0, 5'd0);
    check_comb("r0");
    check("r0/byp", 64'(rd_data_b[DW-1:0]), 64'h0);
    tick("r0");
    check("r0/cnt", 64'(cnt_b), 64'h1);
    idle(); check_comb("r0b");
    check("r0b/data", 64'(rd_data_b[DW-1:0]), 64'h0);

    // Reset in the middle of an issue sequence
    idle(); iss_en = 1'b1; iss_addr = 5'd1; tick("iss1");
    iss_addr = 5'd2; reset = 1'b0; tick("rst_mid");
    reset = 1'b1; idle(); set_rd(0, 5'd4); set_rd(1, 5'd9);
    check_comb("after_rst");
    check("after_rst/r4", 64'(rd_data_b[DW-1:0]), 64'h0);
    check("after_rst/r9", 64'(rd_data_b[2*DW-1:DW]), 64'h0);
    check("after_rst/cnt", 64'(cnt_b), 64'h0);
    check("after_rst/conf", 64'(conf_b), 64'h0);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      idle();
      reset    = ($urandom_range(0, 39) != 0);
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = AW'($urandom_range(0, 15));
      for (int p = 0; p < NW; p++)
        if ($urandom_range(0, 1) == 1) set_wr(p, AW'($urandom_range(0, 15)), $urandom);
      for (int k = 0; k < NR; k++) begin
        if ($urandom_range(0, 2) == 0) set_rd(k, wa(int'($urandom_range(0, NW-1))));
        else set_rd(k, AW'($urandom_range(0, 31)));
      end
      check_comb("rnd");
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
